// File: rtl/seq_detector_pkg.sv
// Shared types for the equal-pair serial detector.
// State enum (3-bit binary) and the reset state used by the detector FSM.
package seq_detector_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ONE0  = 3'd1,
      S_ONE1  = 3'd2,
      S_PAIR0 = 3'd3,
      S_PAIR1 = 3'd4
   } seq_state_e;

   localparam seq_state_e RESET_STATE = S_IDLE;

endpackage : seq_detector_pkg

// File: rtl/seq_detector_2.sv
// Moore FSM that flags when the last two sampled bits of w are equal (00 or 11).
// z is decoded from the state register only, so there is no w-to-z combinational path.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | no valid sample since reset
// S_ONE0  | last sample 0, previous differs or absent
// S_ONE1  | last sample 1, previous differs or absent
// S_PAIR0 | last two samples 00 (z=1)
// S_PAIR1 | last two samples 11 (z=1)
module seq_detector_2
   import seq_detector_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic w,
   output logic z
);

   seq_state_e state_q;
   seq_state_e state_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = RESET_STATE;
      unique case (state_q)
         S_IDLE:  state_d = w ? S_ONE1  : S_ONE0;
         S_ONE0:  state_d = w ? S_ONE1  : S_PAIR0;
         S_ONE1:  state_d = w ? S_PAIR1 : S_ONE0;
         S_PAIR0: state_d = w ? S_ONE1  : S_PAIR0;
         S_PAIR1: state_d = w ? S_PAIR1 : S_ONE0;
         // Unused encodings recover to idle rather than guessing a history.
         default: state_d = RESET_STATE;
      endcase
   end

   assign z = (state_q == S_PAIR0) || (state_q == S_PAIR1);

endmodule : seq_detector_2

// File: tb/tb_seq_detector_2.sv
// Self-checking bench for seq_detector_2: directed streams plus biased random traffic.
// Reference keeps the last two samples since reset and flags when they are equal.
module tb_seq_detector_2;

   logic clk;
   logic reset;
   logic w;
   logic z;

   int total;
   int bad;

   logic hist[$];
   logic prev_w;

   seq_detector_2 u_dut (
      .clk   (clk),
      .reset (reset),
      .w     (w),
      .z     (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got z=%b want z=%b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic model_z();
      return (hist.size() == 2) && (hist[0] == hist[1]);
   endfunction

   // Drive one bit at the falling edge, let the rising edge sample it, then check.
   task automatic step(input logic b, input string tag);
      @(negedge clk);
      w = b;
      @(posedge clk);
      #1;
      if (!reset) begin
         hist.delete();
      end else begin
         hist.push_back(b);
         if (hist.size() > 2) hist.pop_front();
      end
      chk(tag, z, model_z());
   endtask

   task automatic run_seq(input logic [15:0] bits, input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         step(bits[i], tag);
      end
   endtask

   // Short reset pulse between edges; z must drop without any clock edge.
   task automatic rst_pulse(input string tag);
      reset = 1'b0;
      #1;
      hist.delete();
      chk(tag, z, 1'b0);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      w     = 1'b0;
      prev_w = 1'b0;
      #2;
      chk("rst_state", z, 1'b0);

      for (int i = 0; i < 3; i++) begin
         step(logic'(i % 2), "rst_hold");
         chk("rst_hold_zero", z, 1'b0);
      end
      reset = 1'b1;

      // First sample after release never asserts z.
      step(1'b0, "post_rel0");
      chk("post_rel0_const", z, 1'b0);
      step(1'b0, "post_rel1");
      chk("post_rel1_const", z, 1'b1);

      rst_pulse("async_rst_a");
      run_seq(16'b1100_1101, 8, "stream");
      rst_pulse("async_rst_b");
      run_seq(16'b01_0101, 6, "alt");
      chk("alt_end_const", z, 1'b0);
      rst_pulse("async_rst_c");
      run_seq(16'b00001, 5, "run0");
      rst_pulse("async_rst_d");
      run_seq(16'b11110, 5, "run1");

      rst_pulse("async_rst_e");
      step(1'b1, "mid_a");
      step(1'b1, "mid_b");
      chk("mid_pair_const", z, 1'b1);
      rst_pulse("mid_rst");
      step(1'b1, "mid_after0");
      chk("mid_after0_const", z, 1'b0);
      step(1'b1, "mid_after1");
      chk("mid_after1_const", z, 1'b1);

      // Random traffic, biased towards runs, with occasional reset pulses.
      for (int i = 0; i < 600; i++) begin
         logic b;
         if (i < 200) b = logic'($urandom_range(1, 0));
         else b = ($urandom_range(3, 0) == 0) ? ~prev_w : prev_w;
         prev_w = b;
         step(b, "rand");
         if ($urandom_range(39, 0) == 0) rst_pulse("rand_rst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule : tb_seq_detector_2
